pixel_proc_engine: RTL and testbench

Downstream consumer of the slave arbiter in the image-processing accelerator. It buffers the arbitrated pixel words (mode, data, proc value) in a small FIFO and drives fifo_full back to the arbiter. It applies the selected per-byte pixel operation to each 32-bit word of four packed 8-bit pixels. It presents the results on a valid/ready output port with word/frame framing.

---
 rtl/pixel_proc_engine.sv | 184 ++++++++++++++++++
 tb/tb_pixel_proc_engine.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_proc_engine.sv
// -----------------------------------------------------------------------------
// pixel_proc_engine
//
// Consumer of the slave arbiter in the image-processing accelerator. Arbitrated
// pixel words (mode, operand, packed pixels) are buffered in a small FIFO. Each
// popped word goes through a per-byte pixel operation, and the result is
// registered onto a valid/ready output port with word/frame framing.
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-high reset
//   slvx_mode        in   2-bit operation select stored with the word
//   slvx_data        in   DW-bit packed pixels, byte i = bits [8i+7:8i]
//   slvx_proc_val    in   8-bit operand (offset or threshold)
//   slvx_data_valid  in   arbiter word valid
//   fifo_full        out  FIFO holds DEPTH entries (registered)
//   fifo_count       out  FIFO occupancy 0..DEPTH (registered)
//   out_data         out  processed pixels
//   out_valid        out  out_data valid
//   out_ready        in   downstream accepts the presented word
//   out_last         out  presented word is the last of a frame
//   frame_done       out  one-cycle pulse after the last word is accepted
//
// Operations per byte (p = pixel, v = operand):
//   0 pass-through, 1 saturating add, 2 saturating subtract, 3 threshold
// -----------------------------------------------------------------------------
module pixel_proc_engine #(
    parameter int DW              = 32,
    parameter int DEPTH           = 4,
    parameter int WORDS_PER_FRAME = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               slvx_mode,
    input  logic [DW-1:0]            slvx_data,
    input  logic [7:0]               slvx_proc_val,
    input  logic                     slvx_data_valid,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     frame_done
);

    localparam int LANES = DW / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int EW    = DW + 10;
    // A one-word frame still needs a one-bit counter to keep the logic uniform.
    localparam int CW    = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS_PER_FRAME - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    // FIFO entry layout: {mode[1:0], proc_val[7:0], data[DW-1:0]}
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_next;

    logic            push;
    logic            pop;
    logic            out_free;
    logic            accept;

    logic [EW-1:0]   head;
    logic [1:0]      head_mode;
    logic [7:0]      head_val;
    logic [DW-1:0]   head_data;

    logic [CW-1:0]   word_cnt;
    logic [CW-1:0]   word_cnt_next;

    // -------------------------------------------------------------------------
    // Per-lane pixel operation
    // -------------------------------------------------------------------------
    function automatic logic [DW-1:0] pixel_op(
        input logic [1:0]    mode,
        input logic [7:0]    v,
        input logic [DW-1:0] d
    );
        logic [DW-1:0] r;
        logic [7:0]    p;
        logic [8:0]    sum;
        logic [8:0]    diff;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            p    = d[8*i +: 8];
            sum  = {1'b0, p} + {1'b0, v};
            // diff[8] is the borrow: set exactly when p < v.
            diff = {1'b0, p} - {1'b0, v};
            case (mode)
                2'd0:    r[8*i +: 8] = p;
                2'd1:    r[8*i +: 8] = sum[8]  ? 8'hFF : sum[7:0];
                2'd2:    r[8*i +: 8] = diff[8] ? 8'h00 : diff[7:0];
                default: r[8*i +: 8] = (p >= v) ? 8'hFF : 8'h00;
            endcase
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    assign out_free = ~out_valid | out_ready;
    assign accept   = out_valid & out_ready;
    // Registered fifo_full gates the push, so a push at full is simply ignored.
    assign push     = slvx_data_valid & ~fifo_full;
    // Only stored entries can be popped; there is no bypass from the input.
    assign pop      = (fifo_count != '0) & out_free;

    assign head      = mem[rd_ptr];
    assign head_mode = head[EW-1 -: 2];
    assign head_val  = head[DW+7 : DW];
    assign head_data = head[DW-1 : 0];

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_next = fifo_count - 1'b1;
        end
    end

    always_comb begin
        word_cnt_next = word_cnt;
        if (accept) begin
            word_cnt_next = (word_cnt == LAST_IDX) ? '0 : word_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage (contents need no reset; pointers/count define validity)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {slvx_mode, slvx_proc_val, slvx_data};
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, occupancy, output register and frame counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            word_cnt   <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_next;
            fifo_full  <= (count_next == FULL_CNT);

            word_cnt   <= word_cnt_next;
            frame_done <= accept && (word_cnt == LAST_IDX);

            if (pop) begin
                out_data  <= pixel_op(head_mode, head_val, head_data);
                out_valid <= 1'b1;
                // The word loaded now is presented at index word_cnt_next,
                // which already accounts for an acceptance on this edge.
                out_last  <= (word_cnt_next == LAST_IDX);
            end else if (accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_proc_engine.sv
module tb_pixel_proc_engine;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int WPF   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  slvx_mode;
    logic [31:0] slvx_data;
    logic [7:0]  slvx_proc_val;
    logic        slvx_data_valid;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        frame_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];
    int          exp_idx  = 0;

    pixel_proc_engine #(.DW(DW), .DEPTH(DEPTH), .WORDS_PER_FRAME(WPF)) dut (
        .clk(clk), .rst(rst),
        .slvx_mode(slvx_mode), .slvx_data(slvx_data),
        .slvx_proc_val(slvx_proc_val), .slvx_data_valid(slvx_data_valid),
        .fifo_full(fifo_full), .fifo_count(fifo_count),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] m, input logic [7:0] v,
                                          input logic [31:0] d);
        logic [31:0] r;
        int p, q, y;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            p = int'(d[8*i +: 8]);
            q = int'(v);
            case (m)
                2'd0:    y = p;
                2'd1:    y = (p + q > 255) ? 255 : p + q;
                2'd2:    y = (p - q < 0) ? 0 : p - q;
                default: y = (p >= q) ? 255 : 0;
            endcase
            r[8*i +: 8] = y[7:0];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        slvx_data_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_idx = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        slvx_mode = 2'd0; slvx_data = '0; slvx_proc_val = '0;
        slvx_data_valid = 1'b0; out_ready = 1'b0;
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_full: got %b want 0", fifo_full); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_idx = 0;
    endtask

    task automatic test_ops();
        logic [1:0]  vm[12];
        logic [7:0]  vv[12];
        logic [31:0] vd[12];
        logic [31:0] ve[12];
        int np, nr, cyc;
        out_ready = 1'b1;
        // Single pass-through word: latency and fifo_count.
        slvx_mode = 2'd0; slvx_proc_val = 8'h00; slvx_data = 32'h11223344;
        slvx_data_valid = 1'b1;
        step();
        slvx_data_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_no_bypass: got out_valid=%b want 0", out_valid); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL lat_count1: got %0d want 1", fifo_count); end
        step();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 32'h11223344) begin n_fail++; $display("FAIL lat_data: got %h want 11223344", out_data); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL lat_count0: got %0d want 0", fifo_count); end
        exp_idx = (exp_idx + 1) % WPF;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drain: got out_valid=%b want 0", out_valid); end

        // Back-to-back words with a mode change on every word.
        vm[0] = 2'd1; vv[0] = 8'h20; vd[0] = 32'hF0E01000; ve[0] = 32'hFFFF3020;
        vm[1] = 2'd2; vv[1] = 8'h20; vd[1] = 32'hF0E01000; ve[1] = 32'hD0C00000;
        vm[2] = 2'd3; vv[2] = 8'h80; vd[2] = 32'h7F80FF00; ve[2] = 32'h00FFFF00;
        for (int i = 3; i < 12; i++) begin
            vm[i] = 2'($urandom_range(0, 3));
            vv[i] = 8'($urandom);
            vd[i] = $urandom;
            ve[i] = model(vm[i], vv[i], vd[i]);
        end
        np = 0; nr = 0; cyc = 0;
        while (nr < 12 && cyc < 200) begin
            if (out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL ops_unexpected: got %h want no word", out_data); end
                else begin
                    if (out_data !== sb[0]) begin n_fail++; $display("FAIL ops_data[%0d]: got %h want %h", nr, out_data, sb[0]); end
                    void'(sb.pop_front());
                end
                n_checks++; if (out_last !== (exp_idx == WPF-1)) begin n_fail++; $display("FAIL ops_last[%0d]: got %b want %b", nr, out_last, exp_idx == WPF-1); end
                exp_idx = (exp_idx + 1) % WPF;
                nr++;
            end
            if (np < 12 && !fifo_full) begin
                slvx_mode = vm[np]; slvx_proc_val = vv[np]; slvx_data = vd[np];
                slvx_data_valid = 1'b1;
                sb.push_back(ve[np]);
                np++;
            end else begin
                slvx_data_valid = 1'b0;
            end
            step();
            cyc++;
        end
        slvx_data_valid = 1'b0;
        n_checks++; if (nr != 12) begin n_fail++; $display("FAIL ops_timeout: got %0d words want 12", nr); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0]  m;
        logic [7:0]  v;
        int nr, cyc;
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            m = 2'($urandom_range(0, 3)); v = 8'($urandom); d = $urandom;
            slvx_mode = m; slvx_proc_val = v; slvx_data = d; slvx_data_valid = 1'b1;
            n_checks++; if (fifo_full !== (i == 5)) begin n_fail++; $display("FAIL bp_full_before[%0d]: got %b want %b", i, fifo_full, i == 5); end
            if (i < 5) sb.push_back(model(m, v, d));
            step();
        end
        slvx_data_valid = 1'b0;
        n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL bp_full: got %b want 1", fifo_full); end
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", fifo_count); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== sb[0]) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, sb[0]); end
            step();
        end
        out_ready = 1'b1;
        nr = 0; cyc = 0;
        while (nr < 5 && cyc < 50) begin
            if (out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_unexpected: got %h want no word", out_data); end
                else begin
                    if (out_data !== sb[0]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", nr, out_data, sb[0]); end
                    void'(sb.pop_front());
                end
                n_checks++; if (out_last !== (exp_idx == WPF-1)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b want %b", nr, out_last, exp_idx == WPF-1); end
                exp_idx = (exp_idx + 1) % WPF;
                nr++;
            end
            step();
            cyc++;
            if (nr == 1) begin
                n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL bp_full_release: got %b want 0", fifo_full); end
            end
        end
        n_checks++; if (nr != 5) begin n_fail++; $display("FAIL bp_timeout: got %0d words want 5", nr); end
        n_checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL bp_empty: got v=%b cnt=%0d want v=0 cnt=0", out_valid, fifo_count); end
    endtask

    task automatic test_framing();
        logic [1:0]  m;
        logic [7:0]  v;
        logic [31:0] d;
        logic        fd_exp, fd_next;
        int np, nr, cyc, tail, n_pulse, n_last;
        do_reset();
        np = 0; nr = 0; cyc = 0; tail = 0; n_pulse = 0; n_last = 0; fd_exp = 1'b0;
        while (cyc < 600 && (nr < 32 || tail < 2)) begin
            out_ready = ($urandom_range(0, 3) != 0);
            fd_next = 1'b0;
            n_checks++; if (frame_done !== fd_exp) begin n_fail++; $display("FAIL frm_done[cyc %0d]: got %b want %b", cyc, frame_done, fd_exp); end
            if (frame_done) n_pulse++;
            if (out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL frm_unexpected: got %h want no word", out_data); end
                else if (out_data !== sb[0]) begin n_fail++; $display("FAIL frm_data[%0d]: got %h want %h", nr, out_data, sb[0]); end
                n_checks++; if (out_last !== (exp_idx == WPF-1)) begin n_fail++; $display("FAIL frm_last[%0d]: got %b want %b", nr, out_last, exp_idx == WPF-1); end
                if (out_ready) begin
                    if (exp_idx == WPF-1) begin fd_next = 1'b1; n_last++; end
                    if (sb.size() != 0) void'(sb.pop_front());
                    exp_idx = (exp_idx + 1) % WPF;
                    nr++;
                end
            end
            if (np < 32 && !fifo_full) begin
                m = 2'($urandom_range(0, 3)); v = 8'($urandom); d = $urandom;
                slvx_mode = m; slvx_proc_val = v; slvx_data = d; slvx_data_valid = 1'b1;
                sb.push_back(model(m, v, d));
                np++;
            end else begin
                slvx_data_valid = 1'b0;
            end
            step();
            cyc++;
            fd_exp = fd_next;
            if (nr >= 32) tail++;
        end
        slvx_data_valid = 1'b0;
        n_checks++; if (nr != 32) begin n_fail++; $display("FAIL frm_timeout: got %0d words want 32", nr); end
        n_checks++; if (n_pulse != 2) begin n_fail++; $display("FAIL frm_pulses: got %0d want 2", n_pulse); end
        n_checks++; if (n_last != 2) begin n_fail++; $display("FAIL frm_lasts: got %0d want 2", n_last); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        logic        fd_exp, fd_next;
        int np, nr, cyc, tail, n_pulse;
        do_reset();
        out_ready = 1'b1;
        np = 0; nr = 0; cyc = 0;
        while (nr < 5 && cyc < 100) begin
            if (out_valid) begin
                n_checks++; if (out_data !== sb[0]) begin n_fail++; $display("FAIL mid_pre_data[%0d]: got %h want %h", nr, out_data, sb[0]); end
                void'(sb.pop_front());
                exp_idx++;
                nr++;
            end
            d = $urandom;
            slvx_mode = 2'd0; slvx_proc_val = 8'h00; slvx_data = d; slvx_data_valid = 1'b1;
            sb.push_back(d);
            np++;
            step();
            cyc++;
        end
        // Abandon the frame with words still queued in the FIFO.
        rst = 1'b1;
        slvx_data_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out: got v=%b d=%h l=%b want 0", out_valid, out_data, out_last); end
        n_checks++; if (fifo_count !== 3'd0 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fifo: got cnt=%0d full=%b want 0", fifo_count, fifo_full); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_idx = 0;
        np = 0; nr = 0; cyc = 0; tail = 0; n_pulse = 0; fd_exp = 1'b0;
        while (cyc < 200 && (nr < 16 || tail < 2)) begin
            fd_next = 1'b0;
            n_checks++; if (frame_done !== fd_exp) begin n_fail++; $display("FAIL mid_done[cyc %0d]: got %b want %b", cyc, frame_done, fd_exp); end
            if (frame_done) n_pulse++;
            if (out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL mid_unexpected: got %h want no word", out_data); end
                else begin
                    if (out_data !== sb[0]) begin n_fail++; $display("FAIL mid_data[%0d]: got %h want %h", nr, out_data, sb[0]); end
                    void'(sb.pop_front());
                end
                n_checks++; if (out_last !== (nr == 15)) begin n_fail++; $display("FAIL mid_last[%0d]: got %b want %b", nr, out_last, nr == 15); end
                if (nr == 15) fd_next = 1'b1;
                exp_idx = (exp_idx + 1) % WPF;
                nr++;
            end
            if (np < 16 && !fifo_full) begin
                d = $urandom;
                slvx_mode = 2'd0; slvx_proc_val = 8'h00; slvx_data = d; slvx_data_valid = 1'b1;
                sb.push_back(d);
                np++;
            end else begin
                slvx_data_valid = 1'b0;
            end
            step();
            cyc++;
            fd_exp = fd_next;
            if (nr >= 16) tail++;
        end
        slvx_data_valid = 1'b0;
        n_checks++; if (nr != 16) begin n_fail++; $display("FAIL mid_timeout: got %0d words want 16", nr); end
        n_checks++; if (n_pulse != 1) begin n_fail++; $display("FAIL mid_pulses: got %0d want 1", n_pulse); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_framing();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
